rggen_bus_arbiter: RTL and testbench



---
 rtl/rggen_rtl_pkg.sv | 18 +
 rtl/rggen_round_robin_arbiter.sv | 28 ++
 rtl/rggen_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_rggen_bus_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rggen_rtl_pkg.sv
// rggen_rtl_pkg: bus direction/status types and the arbiter state encoding
package rggen_rtl_pkg;
  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;
  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    RESPOND = 2'b10
  } rggen_arbiter_state;
endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// rggen_round_robin_arbiter: picks the first requester after the last winner, wrapping around
module rggen_round_robin_arbiter #(
  parameter int HOSTS = 2
)(
  input  logic [HOSTS-1:0]         request,
  input  logic [$clog2(HOSTS)-1:0] last,
  output logic [HOSTS-1:0]         grant,
  output logic [$clog2(HOSTS)-1:0] index
);
  localparam int IW = $clog2(HOSTS);
  logic          found;
  logic [IW-1:0] j;
  // scan last+1, last+2, ... with wrap and keep the first hit
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 1; i <= HOSTS; i++) begin
      j = IW'((int'(last) + i) % HOSTS);
      if (!found && request[j]) begin
        found    = 1'b1;
        index    = j;
        grant[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rggen_bus_arbiter.sv
// rggen_bus_arbiter: round-robin sharing of one register bus among several hosts
module rggen_bus_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int HOSTS          = 2,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 0
)(
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [HOSTS-1:0]               i_host_valid,
  input  logic [HOSTS-1:0]               i_host_access,
  input  logic [HOSTS*ADDRESS_WIDTH-1:0] i_host_address,
  input  logic [HOSTS*BUS_WIDTH-1:0]     i_host_write_data,
  input  logic [HOSTS*(BUS_WIDTH/8)-1:0] i_host_strobe,
  output logic [HOSTS-1:0]               o_host_ready,
  output rggen_status                    o_host_status,
  output logic [BUS_WIDTH-1:0]           o_host_read_data,
  output logic                           o_bus_valid,
  output rggen_direction                 o_bus_access,
  output logic [ADDRESS_WIDTH-1:0]       o_bus_address,
  output logic [BUS_WIDTH-1:0]           o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]         o_bus_strobe,
  input  logic                           i_bus_ready,
  input  rggen_status                    i_bus_status,
  input  logic [BUS_WIDTH-1:0]           i_bus_read_data,
  output logic [HOSTS-1:0]               o_grant
);
  localparam int SW = BUS_WIDTH / 8;
  localparam int IW = $clog2(HOSTS);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam bit WD_EN = TIMEOUT_CYCLES > 0;
  localparam logic [CW-1:0] LIMIT = CW'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  rggen_arbiter_state     state, state_n;
  logic [IW-1:0]          last, last_n, rr_index;
  logic [HOSTS-1:0]       rr_grant, ready_n, grant_n;
  logic [CW-1:0]          cnt, cnt_n;
  rggen_status            status_n;
  logic [BUS_WIDTH-1:0]   rdata_n, wdata_n;
  logic                   valid_n, timeout;
  rggen_direction         access_n;
  logic [ADDRESS_WIDTH-1:0] address_n;
  logic [SW-1:0]          strobe_n;

  rggen_round_robin_arbiter #(.HOSTS(HOSTS)) u_rr (
    .request (i_host_valid),
    .last    (last),
    .grant   (rr_grant),
    .index   (rr_index)
  );

  assign timeout = WD_EN && (cnt == LIMIT);

  // next-state and next-output logic; every output is registered below
  always_comb begin
    state_n   = state;
    last_n    = last;
    cnt_n     = cnt;
    ready_n   = '0;
    grant_n   = o_grant;
    status_n  = o_host_status;
    rdata_n   = o_host_read_data;
    valid_n   = o_bus_valid;
    access_n  = o_bus_access;
    address_n = o_bus_address;
    wdata_n   = o_bus_write_data;
    strobe_n  = o_bus_strobe;
    case (state)
      IDLE: if (|i_host_valid) begin
        state_n   = BUSY;
        last_n    = rr_index;
        grant_n   = rr_grant;
        valid_n   = 1'b1;
        cnt_n     = '0;
        access_n  = rggen_direction'(i_host_access[rr_index]);
        address_n = i_host_address[rr_index*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        wdata_n   = i_host_write_data[rr_index*BUS_WIDTH +: BUS_WIDTH];
        strobe_n  = i_host_strobe[rr_index*SW +: SW];
      end
      BUSY: if (i_bus_ready || timeout) begin
        state_n  = RESPOND;
        valid_n  = 1'b0;
        ready_n  = o_grant;
        status_n = i_bus_ready ? i_bus_status : RGGEN_SLAVE_ERROR;
        rdata_n  = (i_bus_ready && o_bus_access == RGGEN_READ) ? i_bus_read_data : '0;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      RESPOND: begin
        state_n = IDLE;
        grant_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // state and output registers; reset abandons any transfer in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= IDLE;
      last             <= IW'(HOSTS - 1);
      cnt              <= '0;
      o_host_ready     <= '0;
      o_grant          <= '0;
      o_host_status    <= RGGEN_OKAY;
      o_host_read_data <= '0;
      o_bus_valid      <= 1'b0;
      o_bus_access     <= RGGEN_READ;
      o_bus_address    <= '0;
      o_bus_write_data <= '0;
      o_bus_strobe     <= '0;
    end else begin
      state            <= state_n;
      last             <= last_n;
      cnt              <= cnt_n;
      o_host_ready     <= ready_n;
      o_grant          <= grant_n;
      o_host_status    <= status_n;
      o_host_read_data <= rdata_n;
      o_bus_valid      <= valid_n;
      o_bus_access     <= access_n;
      o_bus_address    <= address_n;
      o_bus_write_data <= wdata_n;
      o_bus_strobe     <= strobe_n;
    end
  end
endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// tb_rggen_bus_arbiter: directed and randomized transfers checked against a round-robin model
module tb_rggen_bus_arbiter;
  import rggen_rtl_pkg::*;
  localparam int H = 3, AW = 16, DW = 32, SW = 4, TO = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic [H-1:0] hv = '0, hacc = '0;
  logic [H*AW-1:0] haddr = '0;
  logic [H*DW-1:0] hwd = '0;
  logic [H*SW-1:0] hstb = '0;
  logic [H-1:0] hready, grant;
  rggen_status hstat;
  logic [DW-1:0] hrdata, bwd;
  logic bvalid;
  rggen_direction bacc;
  logic [AW-1:0] baddr;
  logic [SW-1:0] bstb;
  logic bready = 1'b0;
  rggen_status bstatus = RGGEN_OKAY;
  logic [DW-1:0] brdata = '0;

  int checks = 0, errors = 0, mlast = H - 1, lw = 0;
  logic [H-1:0] restore = '0, add, nhv;

  rggen_bus_arbiter #(
    .HOSTS(H), .ADDRESS_WIDTH(AW), .BUS_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_host_valid(hv), .i_host_access(hacc), .i_host_address(haddr),
    .i_host_write_data(hwd), .i_host_strobe(hstb),
    .o_host_ready(hready), .o_host_status(hstat), .o_host_read_data(hrdata),
    .o_bus_valid(bvalid), .o_bus_access(bacc), .o_bus_address(baddr),
    .o_bus_write_data(bwd), .o_bus_strobe(bstb),
    .i_bus_ready(bready), .i_bus_status(bstatus), .i_bus_read_data(brdata),
    .o_grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    checks++;
    assert ($onehot0(grant)) else begin
      errors++;
      $error("FAIL grant_onehot: observed %b expected at most one bit", grant);
    end
  end

  function automatic int pick(input logic [H-1:0] v, input int last);
    for (int i = 1; i <= H; i++) if (v[(last + i) % H]) return (last + i) % H;
    return -1;
  endfunction

  task automatic set_host(input int h, input logic a, input logic [AW-1:0] ad,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
    hacc[h] = a;
    haddr[h*AW +: AW] = ad;
    hwd[h*DW +: DW] = d;
    hstb[h*SW +: SW] = s;
  endtask

  task automatic rand_host(input int h);
    set_host(h, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, SW'($urandom_range(1, 15)));
  endtask

  // one full transfer starting in an IDLE cycle with requests already driven
  task automatic xfer(input int wt, input bit to, input rggen_status st,
                      input logic [DW-1:0] rd, input bit cont, output int w);
    logic ea;
    logic [AW-1:0] ead;
    logic [DW-1:0] ewd, erd;
    logic [SW-1:0] es;
    int nb;
    w = pick(hv, mlast);
    if (w < 0) begin
      chk("no_request", 32'(hv), 32'(1));
      return;
    end
    mlast = w;
    ea  = hacc[w];
    ead = haddr[w*AW +: AW];
    ewd = hwd[w*DW +: DW];
    es  = hstb[w*SW +: SW];
    erd = (to || ea) ? '0 : rd;
    nb  = to ? TO : wt + 1;
    @(posedge clk); #1;
    hv = hv | restore;
    restore = '0;
    for (int b = 0; b < nb; b++) begin
      if (b > 0) begin @(posedge clk); #1; end
      if (!to && b == wt) begin
        bready = 1'b1;
        bstatus = st;
        brdata = rd;
      end
      @(negedge clk);
      chk("bus_valid", 32'(bvalid), 32'(1));
      chk("grant", 32'(grant), 32'(1) << w);
      chk("bus_access", 32'(bacc), 32'(ea));
      chk("bus_address", 32'(baddr), 32'(ead));
      chk("bus_wdata", bwd, ewd);
      chk("bus_strobe", 32'(bstb), 32'(es));
      chk("ready_early", 32'(hready), 32'(0));
    end
    @(posedge clk); #1;
    bready = 1'b0;
    hv[w] = 1'b0;
    if (cont) restore[w] = 1'b1;
    @(negedge clk);
    chk("host_ready", 32'(hready), 32'(1) << w);
    chk("host_status", 32'(hstat), to ? 32'(RGGEN_SLAVE_ERROR) : 32'(st));
    chk("host_rdata", hrdata, erd);
    chk("bus_valid_drop", 32'(bvalid), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_pulse", 32'(hready), 32'(0));
    chk("grant_clear", 32'(grant), 32'(0));
  endtask

  initial begin
    @(negedge clk);
    chk("rst_bus_valid", 32'(bvalid), 32'(0));
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_host_ready", 32'(hready), 32'(0));
    chk("rst_access", 32'(bacc), 32'(RGGEN_READ));
    chk("rst_status", 32'(hstat), 32'(RGGEN_OKAY));
    chk("rst_rdata", hrdata, 32'(0));
    @(posedge clk); #1 rst = 1'b0;
    // single read from host 0, two wait states downstream
    set_host(0, RGGEN_READ, 16'h0010, 32'h0, 4'hf);
    hv = 3'b001;
    xfer(2, 0, RGGEN_OKAY, 32'hDEADBEEF, 0, lw);
    // write with partial strobe from host 1
    set_host(1, RGGEN_WRITE, 16'h0024, 32'h12345678, 4'b0011);
    hv = 3'b010;
    xfer(0, 0, RGGEN_EXOKAY, 32'hCAFEF00D, 0, lw);
    // hosts 0 and 1 together, zero-wait downstream
    set_host(0, RGGEN_READ, 16'h0100, 32'h0, 4'hf);
    set_host(1, RGGEN_READ, 16'h0200, 32'h0, 4'hf);
    hv = 3'b011;
    xfer(0, 0, RGGEN_OKAY, 32'h11111111, 0, lw);
    xfer(0, 0, RGGEN_OKAY, 32'h22222222, 0, lw);
    // watchdog on host 2, then a stray ready that must be ignored
    set_host(2, RGGEN_READ, 16'h0300, 32'h0, 4'hf);
    hv = 3'b100;
    xfer(0, 1, RGGEN_OKAY, 32'h33333333, 0, lw);
    bready = 1'b1;
    bstatus = RGGEN_OKAY;
    brdata = 32'h55555555;
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    chk("stray_bus_valid", 32'(bvalid), 32'(0));
    chk("stray_host_ready", 32'(hready), 32'(0));
    chk("stray_grant", 32'(grant), 32'(0));
    // all three hosts requesting continuously
    for (int h = 0; h < H; h++) rand_host(h);
    hv = 3'b111;
    for (int i = 0; i < 9; i++)
      xfer($urandom_range(0, 2), 0, rggen_status'($urandom_range(0, 3)), $urandom, 1, lw);
    restore = '0;
    // random traffic
    for (int i = 0; i < 40; i++) begin
      add = 3'($urandom_range(0, 7)) & ~(3'(1) << lw);
      nhv = hv | add;
      if (nhv == '0) nhv = 3'(1) << ((lw + 1) % H);
      for (int h = 0; h < H; h++) if (nhv[h] && !hv[h]) rand_host(h);
      hv = nhv;
      xfer($urandom_range(0, 3), $urandom_range(0, 7) == 0, rggen_status'($urandom_range(0, 3)),
           $urandom, 0, lw);
    end
    // reset in the middle of a transfer
    hv = '0;
    @(posedge clk); #1;
    set_host(1, RGGEN_WRITE, 16'h0400, 32'hA5A5A5A5, 4'hf);
    hv = 3'b010;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_bus_valid", 32'(bvalid), 32'(1));
    chk("mid_grant", 32'(grant), 32'(3'b010));
    #2 rst = 1'b1;
    #1;
    chk("arst_bus_valid", 32'(bvalid), 32'(0));
    chk("arst_grant", 32'(grant), 32'(0));
    chk("arst_host_ready", 32'(hready), 32'(0));
    mlast = H - 1;
    for (int h = 0; h < H; h++) rand_host(h);
    hv = 3'b111;
    @(posedge clk); #1 rst = 1'b0;
    xfer(1, 0, RGGEN_OKAY, 32'h0BADC0DE, 0, lw);
    chk("post_rst_winner", 32'(lw), 32'(0));
    hv = '0;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
